// File: rtl/latency_data_memory.sv
// Line-wide data memory with a fixed access latency, a valid/ready request
// port and a one-cycle response pulse. Writes use per-byte enables.
module latency_data_memory #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_DEPTH  = 4096,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic                    resp_is_write,
  output logic [DATA_WIDTH-1:0]   dout
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int LINE_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    op_write_q, op_write_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [BE_W-1:0]         ben_q, ben_d;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic [LINE_W-1:0]       req_line;
  logic                    accept;
  logic                    commit;

  // Non-power-of-two depths still wrap correctly thanks to the modulo.
  assign req_line = LINE_W'((addr >> OFF_W) % 32'(MEM_DEPTH));
  assign is_ready = (state_q != BUSY);
  assign accept   = is_input_valid && is_ready && (mem_read ^ mem_write);
  // The array access happens on the edge that leaves BUSY.
  assign commit   = (state_q == BUSY) && (cnt_q == '0);

  assign is_output_valid = (state_q == RESP);
  assign resp_is_write   = (state_q == RESP) && op_write_q;
  assign dout            = dout_q;

  // Control state and the latched request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      op_write_q <= 1'b0;
      din_q      <= '0;
      ben_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      op_write_q <= op_write_d;
      din_q      <= din_d;
      ben_q      <= ben_d;
    end
  end

  // Next-state logic; a request is latched whenever it is accepted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    op_write_d = op_write_q;
    din_d      = din_q;
    ben_d      = ben_q;
    if (accept) begin
      line_d     = req_line;
      op_write_d = mem_write;
      din_d      = din;
      ben_d      = byte_en;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = RESP;
      end
      RESP: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array; reset clears every line, writes merge enabled bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < MEM_DEPTH; l++) mem_q[l] <= '0;
    end else if (commit && op_write_q) begin
      for (int i = 0; i < BE_W; i++) begin
        if (ben_q[i]) mem_q[line_q][8*i +: 8] <= din_q[8*i +: 8];
      end
    end
  end

  // Read data register; holds between read responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     dout_q <= '0;
    else if (commit && !op_write_q) dout_q <= mem_q[line_q];
  end

endmodule

// File: tb/tb_latency_data_memory.sv
// Directed bench for latency_data_memory with hand-computed expectations.
module tb_latency_data_memory;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] din;
  logic [15:0]  byte_en;
  logic         is_ready;
  logic         is_output_valid;
  logic         resp_is_write;
  logic [127:0] dout;

  int total = 0;
  int bad   = 0;

  latency_data_memory #(
    .DATA_WIDTH(128),
    .MEM_DEPTH (4096),
    .LATENCY   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (is_input_valid),
    .addr           (addr),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .din            (din),
    .byte_en        (byte_en),
    .is_ready       (is_ready),
    .is_output_valid(is_output_valid),
    .resp_is_write  (resp_is_write),
    .dout           (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] ONES  = {128{1'b1}};
  localparam logic [127:0] D11   = {16{8'h11}};
  localparam logic [127:0] D22   = {16{8'h22}};
  localparam logic [127:0] DA5   = {16{8'hA5}};
  localparam logic [127:0] D77   = {16{8'h77}};
  localparam logic [127:0] PART  = {{112{1'b1}}, 16'h0000};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr           = '0;
    din            = '0;
    byte_en        = '0;
  endtask

  // Issue one request, then count edges from acceptance to the response.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [127:0] d,
                        input logic [15:0] be, output int lat,
                        output logic [127:0] rdata, output logic rwr);
    int g;
    g = 0;
    while (!is_ready && g < 20) begin
      tick();
      g++;
    end
    is_input_valid = 1'b1;
    mem_read       = !wr;
    mem_write      = wr;
    addr           = a;
    din            = d;
    byte_en        = be;
    tick();
    idle_inputs();
    lat = 0;
    while (!is_output_valid && lat < 30) begin
      tick();
      lat++;
    end
    rdata = dout;
    rwr   = resp_is_write;
  endtask

  int           lat;
  logic [127:0] rd;
  logic         rw;
  bit           seen_valid;
  bit           ready_low;

  initial begin
    idle_inputs();
    reset = 1'b1;
    #12;
    chk("rst_ready", 128'(is_ready), 128'd1);
    chk("rst_valid", 128'(is_output_valid), 128'd0);
    chk("rst_rwr",   128'(resp_is_write), 128'd0);
    chk("rst_dout",  dout, 128'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: read of a zeroed line
    do_req(1'b0, 32'h40, '0, '0, lat, rd, rw);
    chk("t1_lat",  128'(lat), 128'd4);
    chk("t1_dout", rd, 128'd0);
    chk("t1_rwr",  128'(rw), 128'd0);
    tick();
    chk("t1_pulse", 128'(is_output_valid), 128'd0);

    // 2: full write then read from another byte offset in the same line
    do_req(1'b1, 32'h100, D11, 16'hFFFF, lat, rd, rw);
    chk("t2_wlat", 128'(lat), 128'd4);
    chk("t2_wack", 128'(rw), 128'd1);
    chk("t2_wdout", rd, 128'd0);
    do_req(1'b0, 32'h10C, '0, '0, lat, rd, rw);
    chk("t2_rlat",  128'(lat), 128'd4);
    chk("t2_rdata", rd, D11);

    // 3: partial write clears bytes 0-1 only
    do_req(1'b1, 32'h200, ONES, 16'hFFFF, lat, rd, rw);
    do_req(1'b1, 32'h200, '0, 16'h0003, lat, rd, rw);
    chk("t3_ack", 128'(rw), 128'd1);
    chk("t3_dout_hold", rd, D11);
    do_req(1'b0, 32'h200, '0, '0, lat, rd, rw);
    chk("t3_rdata", rd, PART);

    // 4: requests during BUSY are ignored, back-to-back accept in RESP
    is_input_valid = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h100;
    tick();
    is_input_valid = 1'b1;
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h100; din = D22; byte_en = 16'hFFFF;
    ready_low = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (is_ready) ready_low = 1'b0;
      if (i == 1) begin
        mem_read = 1'b1; mem_write = 1'b0; addr = 32'h200; din = '0; byte_en = '0;
      end
      tick();
    end
    chk("t4_busy_ready", 128'(ready_low), 128'd1);
    tick();
    chk("t4_resp1",  128'(is_output_valid), 128'd1);
    chk("t4_rdy_resp", 128'(is_ready), 128'd1);
    chk("t4_data1",  dout, D11);
    tick();
    idle_inputs();
    chk("t4_accepted", 128'(is_ready), 128'd0);
    lat = 0;
    while (!is_output_valid && lat < 30) begin
      tick();
      lat++;
    end
    chk("t4_lat2",  128'(lat), 128'd4);
    chk("t4_data2", dout, PART);
    do_req(1'b0, 32'h100, '0, '0, lat, rd, rw);
    chk("t4_nowrite", rd, D11);

    // 5: illegal op encodings, then address wrap
    seen_valid = 1'b0;
    ready_low  = 1'b0;
    is_input_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_read  = (i < 5);
      mem_write = (i < 5);
      addr      = 32'h40;
      tick();
      if (is_output_valid) seen_valid = 1'b1;
      if (!is_ready)       ready_low  = 1'b1;
    end
    idle_inputs();
    chk("t5_no_resp",  128'(seen_valid), 128'd0);
    chk("t5_ready_hi", 128'(ready_low), 128'd0);
    do_req(1'b1, 32'h10000, DA5, 16'hFFFF, lat, rd, rw);
    chk("t5_wack", 128'(rw), 128'd1);
    do_req(1'b0, 32'h0, '0, '0, lat, rd, rw);
    chk("t5_wrap", rd, DA5);
    do_req(1'b0, 32'h10008, '0, '0, lat, rd, rw);
    chk("t5_wrap2", rd, DA5);

    // 6: reset in the second BUSY cycle drops the write
    is_input_valid = 1'b1;
    mem_write = 1'b1; mem_read = 1'b0; addr = 32'h300; din = D77; byte_en = 16'hFFFF;
    tick();
    idle_inputs();
    tick();
    chk("t6_busy", 128'(is_ready), 128'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", 128'(is_ready), 128'd1);
    chk("t6_rst_valid", 128'(is_output_valid), 128'd0);
    chk("t6_rst_dout",  dout, 128'd0);
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (is_output_valid) seen_valid = 1'b1;
    end
    chk("t6_no_ack", 128'(seen_valid), 128'd0);
    do_req(1'b0, 32'h300, '0, '0, lat, rd, rw);
    chk("t6_lat",   128'(lat), 128'd4);
    chk("t6_line0", rd, 128'd0);
    do_req(1'b0, 32'h100, '0, '0, lat, rd, rw);
    chk("t6_cleared", rd, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
